// File: rtl/sram_port_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sram_pkg
// Description : Shared constants and types for the SRAM port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package sram_pkg;

    localparam int c_DEFAULT_DATA_WIDTH = 32;
    localparam int c_DEFAULT_ADDR_BITS  = 10;
    localparam int c_WBE_BITS           = 4;

    typedef enum logic [1:0] {
        ARB   = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } arb_state_e;

    // One-hot grant for two requesters; on contention the port not granted
    // most recently wins (last_p1 = 1 means port 1 was granted last).
    function automatic logic [1:0] rr_pick(input logic [1:0] req,
                                           input logic       last_p1);
        logic [1:0] gnt;
        gnt = req;
        if (req == 2'b11) begin
            gnt = last_p1 ? 2'b01 : 2'b10;
        end
        return gnt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sram_port_arb_if.sv
`default_nettype none
// ============================================================================
// Module      : sram_port_arb_if
// Description : Requester ports and SRAM command/response bundle of the arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface sram_port_arb_if #(
    parameter int DATA_WIDTH = sram_pkg::c_DEFAULT_DATA_WIDTH,
    parameter int ADDR_BITS  = sram_pkg::c_DEFAULT_ADDR_BITS
);

    logic                             p0_req_i;
    logic                             p0_we_i;
    logic [sram_pkg::c_WBE_BITS-1:0]  p0_wbe_i;
    logic [ADDR_BITS-1:0]             p0_addr_i;
    logic [DATA_WIDTH-1:0]            p0_wdata_i;
    logic                             p0_lock_i;
    logic                             p0_gnt_o;
    logic [DATA_WIDTH-1:0]            p0_rdata_o;
    logic                             p0_rvalid_o;

    logic                             p1_req_i;
    logic                             p1_we_i;
    logic [sram_pkg::c_WBE_BITS-1:0]  p1_wbe_i;
    logic [ADDR_BITS-1:0]             p1_addr_i;
    logic [DATA_WIDTH-1:0]            p1_wdata_i;
    logic                             p1_lock_i;
    logic                             p1_gnt_o;
    logic [DATA_WIDTH-1:0]            p1_rdata_o;
    logic                             p1_rvalid_o;

    logic                             mem_en_o;
    logic                             mem_we_o;
    logic [sram_pkg::c_WBE_BITS-1:0]  mem_wbe_o;
    logic [ADDR_BITS-1:0]             mem_addr_o;
    logic [DATA_WIDTH-1:0]            mem_wdata_o;
    logic [DATA_WIDTH-1:0]            mem_rdata_i;

    // Arbiter view.
    modport slave (
        input  p0_req_i, p0_we_i, p0_wbe_i, p0_addr_i, p0_wdata_i, p0_lock_i,
        output p0_gnt_o, p0_rdata_o, p0_rvalid_o,
        input  p1_req_i, p1_we_i, p1_wbe_i, p1_addr_i, p1_wdata_i, p1_lock_i,
        output p1_gnt_o, p1_rdata_o, p1_rvalid_o,
        output mem_en_o, mem_we_o, mem_wbe_o, mem_addr_o, mem_wdata_o,
        input  mem_rdata_i
    );

    // Requester plus SRAM-side view.
    modport master (
        output p0_req_i, p0_we_i, p0_wbe_i, p0_addr_i, p0_wdata_i, p0_lock_i,
        input  p0_gnt_o, p0_rdata_o, p0_rvalid_o,
        output p1_req_i, p1_we_i, p1_wbe_i, p1_addr_i, p1_wdata_i, p1_lock_i,
        input  p1_gnt_o, p1_rdata_o, p1_rvalid_o,
        input  mem_en_o, mem_we_o, mem_wbe_o, mem_addr_o, mem_wdata_o,
        output mem_rdata_i
    );

endinterface
`default_nettype wire

// File: rtl/sram_port_arb_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : sram_rr_arb2
// Description : Two-input round-robin grant logic with last-granted pointer.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_rr_arb2
    import sram_pkg::*;
(
    input  wire logic       hclk_i,
    input  wire logic       hrst_i,
    input  wire logic [1:0] req_i,
    output logic      [1:0] gnt_o
);

    logic last_p1_q;
    logic last_p1_d;

    assign gnt_o = rr_pick(req_i, last_p1_q);

    // Idle cycles leave the pointer alone so fairness survives gaps.
    always_comb begin : ptr_next
        last_p1_d = last_p1_q;
        if (|gnt_o) begin
            last_p1_d = gnt_o[1];
        end
    end

    always_ff @(posedge hclk_i) begin : ptr_reg
        if (hrst_i) begin
            last_p1_q <= 1'b1;
        end else begin
            last_p1_q <= last_p1_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/sram_port_arb.sv
`default_nettype none
// ============================================================================
// Module      : sram_port_arb
// Description : Two-port round-robin arbiter in front of a single-port SRAM.
//               Grant locking is built only with SRAM_PORT_ARB_LOCK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_port_arb
    import sram_pkg::*;
#(
    parameter int DATA_WIDTH = c_DEFAULT_DATA_WIDTH,
    parameter int ADDR_BITS  = c_DEFAULT_ADDR_BITS,
    parameter int MEM_DEPTH  = 2 ** ADDR_BITS
) (
    input  wire logic      hclk_i,
    input  wire logic      hrst_i,
    sram_port_arb_if.slave bus
);

    logic [1:0] w_req_in;
    logic [1:0] w_req;
    logic [1:0] w_gnt;
    logic [1:0] w_lock;
    logic [1:0] w_we;

    logic w_unused_cfg;
    assign w_unused_cfg = (MEM_DEPTH != (1 << ADDR_BITS));

    // Requests are suppressed during reset so nothing reaches the SRAM.
    assign w_req_in = hrst_i ? 2'b00 : {bus.p1_req_i, bus.p0_req_i};
    assign w_lock   = {bus.p1_lock_i, bus.p0_lock_i};
    assign w_we     = {bus.p1_we_i, bus.p0_we_i};

`ifdef SRAM_PORT_ARB_LOCK_EN
    arb_state_e state_q;
    arb_state_e state_d;

    // A locked port keeps exclusive access while it requests with lock held.
    always_comb begin : lock_mask
        w_req = w_req_in;
        if (state_q == LOCK0 && w_req_in[0] && w_lock[0]) begin
            w_req = 2'b01;
        end else if (state_q == LOCK1 && w_req_in[1] && w_lock[1]) begin
            w_req = 2'b10;
        end
    end

    // Leaving a lock re-arbitrates in the same cycle, so every state shares
    // one rule: the next state follows whoever is granted with lock set.
    always_comb begin : fsm_next
        state_d = ARB;
        unique case (state_q)
            ARB, LOCK0, LOCK1: begin
                if (w_gnt[0] && w_lock[0]) begin
                    state_d = LOCK0;
                end else if (w_gnt[1] && w_lock[1]) begin
                    state_d = LOCK1;
                end
            end
            default: state_d = ARB;
        endcase
    end

    always_ff @(posedge hclk_i) begin : fsm_reg
        if (hrst_i) begin
            state_q <= ARB;
        end else begin
            state_q <= state_d;
        end
    end
`else
    logic w_unused_lock;
    assign w_unused_lock = ^w_lock;
    assign w_req         = w_req_in;
`endif

    sram_rr_arb2 u_rr_arb2 (
        .hclk_i (hclk_i),
        .hrst_i (hrst_i),
        .req_i  (w_req),
        .gnt_o  (w_gnt)
    );

    assign bus.p0_gnt_o = w_gnt[0];
    assign bus.p1_gnt_o = w_gnt[1];

    logic                  w_mem_we;
    logic [c_WBE_BITS-1:0] w_mem_wbe;
    logic [ADDR_BITS-1:0]  w_mem_addr;
    logic [DATA_WIDTH-1:0] w_mem_wdata;

    always_comb begin : cmd_mux
        w_mem_we    = 1'b0;
        w_mem_wbe   = '0;
        w_mem_addr  = '0;
        w_mem_wdata = '0;
        if (w_gnt[0]) begin
            w_mem_we    = bus.p0_we_i;
            w_mem_wbe   = bus.p0_wbe_i;
            w_mem_addr  = bus.p0_addr_i;
            w_mem_wdata = bus.p0_wdata_i;
        end else if (w_gnt[1]) begin
            w_mem_we    = bus.p1_we_i;
            w_mem_wbe   = bus.p1_wbe_i;
            w_mem_addr  = bus.p1_addr_i;
            w_mem_wdata = bus.p1_wdata_i;
        end
    end

    assign bus.mem_en_o    = |w_gnt;
    assign bus.mem_we_o    = w_mem_we;
    assign bus.mem_wbe_o   = w_mem_wbe;
    assign bus.mem_addr_o  = w_mem_addr;
    assign bus.mem_wdata_o = w_mem_wdata;

    // Owner of the read whose data the SRAM returns next cycle.
    logic [1:0] rd_own_q;
    logic [1:0] rd_own_d;

    assign rd_own_d = w_gnt & ~w_we;

    always_ff @(posedge hclk_i) begin : rd_own_reg
        if (hrst_i) begin
            rd_own_q <= 2'b00;
        end else begin
            rd_own_q <= rd_own_d;
        end
    end

    logic [1:0] w_rvalid;
    assign w_rvalid = hrst_i ? 2'b00 : rd_own_q;

    assign bus.p0_rvalid_o = w_rvalid[0];
    assign bus.p1_rvalid_o = w_rvalid[1];
    assign bus.p0_rdata_o  = w_rvalid[0] ? bus.mem_rdata_i : '0;
    assign bus.p1_rdata_o  = w_rvalid[1] ? bus.mem_rdata_i : '0;

endmodule
`default_nettype wire

// File: doc/sram_port_arb.md
SRAM_PORT_ARB -- requirements
Module: sram_port_arb

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, SRAM word width.
REQ-002 SHALL have parameter ADDR_BITS, default 10, SRAM word-address width.
REQ-003 SHALL have parameter MEM_DEPTH, default 1024, SRAM depth in words, equal to 2**ADDR_BITS.
REQ-004 SHALL have port hclk_i, input, 1: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port hrst_i, input, 1: reset, synchronous, active-high.
REQ-006 SHALL have ports pN_req_i, input, 1, N=0,1: access request.
REQ-007 SHALL have ports pN_we_i, input, 1: write when 1, read when 0.
REQ-008 SHALL have ports pN_wbe_i, input, 4: byte write enables.
REQ-009 SHALL have ports pN_addr_i, input, ADDR_BITS: word address.
REQ-010 SHALL have ports pN_wdata_i, input, DATA_WIDTH: write data.
REQ-011 SHALL have ports pN_lock_i, input, 1: hold the grant across consecutive accesses.
REQ-012 SHALL have ports pN_gnt_o, output, 1: the request is issued to the SRAM this cycle.
REQ-013 SHALL have ports pN_rdata_o, output, DATA_WIDTH: read data.
REQ-014 SHALL have ports pN_rvalid_o, output, 1: pN_rdata_o is valid this cycle.
REQ-015 SHALL have ports mem_en_o, mem_we_o (1), mem_wbe_o (4), mem_addr_o (ADDR_BITS), mem_wdata_o (DATA_WIDTH), all outputs: SRAM command.
REQ-016 SHALL have port mem_rdata_i, input, DATA_WIDTH: SRAM read data, valid one cycle after a read command.

Function
REQ-017 SHALL grant at most one port per cycle; pN_gnt_o is combinational from the requests and the registered arbitration state.
REQ-018 SHALL drive mem_en_o = p0_gnt_o | p1_gnt_o, with the other mem_* outputs muxed from the granted port.
REQ-019 SHALL drive mem_we_o=0, mem_wbe_o=0, mem_addr_o=0 and mem_wdata_o=0 when no port is granted.
REQ-020 SHALL grant a single requesting port in the same cycle.
REQ-021 SHALL resolve two requests in the same cycle round-robin: grant the port not granted most recently; after reset, port 0 wins.
REQ-022 SHALL update the last-granted pointer only on cycles with a grant.
REQ-023 SHALL hold the request and its command fields stable at the requester until pN_gnt_o=1; this is a requester obligation.
REQ-024 SHALL register, for each granted read, the owning port, and assert that port's pN_rvalid_o for exactly one cycle on the following cycle, with pN_rdata_o=mem_rdata_i.
REQ-025 SHALL never assert rvalid for a write; pN_rdata_o SHALL be 0 whenever pN_rvalid_o=0.
REQ-026 SHALL support back-to-back reads at full rate, e.g. alternating ports: one rvalid per cycle, in grant order.
REQ-027 SHALL use an FSM with states ARB, LOCK0 and LOCK1.
REQ-028 SHALL move ARB -> LOCKn when port n is granted with pn_lock_i=1.
REQ-029 SHALL move LOCKn -> ARB on the first cycle pn_lock_i=0 or pn_req_i=0, re-arbitrating in that same cycle.
REQ-030 SHALL, in LOCKn, grant only port n; the other port waits.

Reset
REQ-031 SHALL, with hrst_i=1 at a clock edge, set the FSM to ARB, the pointer to "port 1 last", and all registered read-owner flags to 0.
REQ-032 SHALL keep pN_gnt_o=0 and mem_en_o=0 while hrst_i=1, with all other outputs 0 on the following cycle.
REQ-033 SHALL discard a read in flight when reset is asserted; no rvalid is asserted after reset.

Configuration
REQ-034 SHALL compile the lock states in only when SRAM_PORT_ARB_LOCK_EN is defined.
REQ-035 SHALL, without SRAM_PORT_ARB_LOCK_EN, keep the pN_lock_i ports present but ignore them, with the FSM permanently ARB (pure round-robin).

Structure
REQ-036 SHALL define the FSM state enum (ARB/LOCK0/LOCK1) and the default DATA_WIDTH/ADDR_BITS constants in shared package sram_pkg.
REQ-037 SHALL place the two-input round-robin grant logic and pointer in sub-module sram_rr_arb2.

Verification
REQ-038 SHALL cover: a p0 write (addr 0x010, wdata 0xDEADBEEF, wbe 0xF), then a p0 read of 0x010 -> p0_gnt_o=1 in the same cycle, p0_rvalid_o=1 with 0xDEADBEEF one cycle after the read grant, and p1_rvalid_o=0.
REQ-039 SHALL cover: both ports holding read requests for 4 cycles after reset -> grants p0,p1,p0,p1; rvalids the same sequence delayed one cycle.
REQ-040 SHALL cover (lock enabled): p0 with lock=1 for 3 reads while p1 requests -> three p0 grants, then p1 granted on the cycle p0_lock_i drops.
REQ-041 SHALL cover (lock disabled): the same stimulus as REQ-040 -> strict alternation p0,p1,p0,p1.
REQ-042 SHALL cover: hrst_i asserted the cycle after a p1 read grant -> p1_rvalid_o stays 0, and the next contended grant goes to p0.
REQ-043 SHALL cover: p1 write with wbe=0x3 to 0x3FF (wrap-top address) -> mem_wbe_o=0x3, mem_addr_o=0x3FF, and no rvalid on either port.
